// File: rtl/des_region_scheduler_if.sv
// Job, result and per-core worker signals of des_region_scheduler.
// The abort input exists only when DES_SCHED_ABORT_EN is defined.
interface des_region_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int REGION_W  = 32
);
  logic                      start;
  logic [REGION_W-1:0]       region_base;
  logic [REGION_W-1:0]       region_count;
  logic                      busy;
  logic                      job_done;
  logic                      res_valid;
  logic                      res_ready;
  logic [REGION_W-1:0]       res_region;
  logic [63:0]               res_counter;
  logic [32*NUM_CORES-1:0]   wk_cmd;
  logic [NUM_CORES-1:0]      wk_cmd_valid;
  logic [32*NUM_CORES-1:0]   wk_region;
  logic [NUM_CORES-1:0]      wk_cmd_read;
  logic [NUM_CORES-1:0]      wk_done;
  logic [64*NUM_CORES-1:0]   wk_counter;
`ifdef DES_SCHED_ABORT_EN
  logic                      abort;
`endif

  modport master (
`ifdef DES_SCHED_ABORT_EN
    output abort,
`endif
    output start, region_base, region_count, res_ready,
    output wk_cmd_read, wk_done, wk_counter,
    input  busy, job_done, res_valid, res_region, res_counter,
    input  wk_cmd, wk_cmd_valid, wk_region
  );

  modport slave (
`ifdef DES_SCHED_ABORT_EN
    input  abort,
`endif
    input  start, region_base, region_count, res_ready,
    input  wk_cmd_read, wk_done, wk_counter,
    output busy, job_done, res_valid, res_region, res_counter,
    output wk_cmd, wk_cmd_valid, wk_region
  );
endinterface

// File: rtl/des_region_scheduler.sv
// Dispatches a contiguous range of regions to NUM_CORES DES wrapper cores and
// serialises their results. Optional abort input under DES_SCHED_ABORT_EN.
module des_region_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int REGION_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  des_region_scheduler_if.slave bus
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [31:0] CMD_READ_REGION = 32'd0;
  localparam logic [31:0] CMD_START       = 32'd1;
  localparam logic [31:0] CMD_RESTART     = 32'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LOAD_REL, S_GO, S_GO_REL, S_RUN, S_REPORT, S_RST, S_RST_REL
  } core_state_e;

  core_state_e         state_q [NUM_CORES];
  core_state_e         state_d [NUM_CORES];
  logic [REGION_W-1:0] region_q [NUM_CORES];
  logic [REGION_W-1:0] next_region_q, next_region_d;
  logic [REGION_W-1:0] remaining_q, remaining_d;
  logic                busy_q, busy_d;
  logic                job_done_q, job_done_d;
  logic                res_valid_q, res_valid_d;
  logic [REGION_W-1:0] res_region_q;
  logic [63:0]         res_counter_q;
  logic [PTR_W-1:0]    last_grant_q, last_cap_q;

  logic                grant_en, cap_en, all_idle, abort_w;
  logic [PTR_W-1:0]    grant_idx, cap_idx, gp, cp;
  logic [63:0]         cap_counter;

`ifdef DES_SCHED_ABORT_EN
  assign abort_w = bus.abort & busy_q;
`else
  assign abort_w = 1'b0;
`endif

  // Round-robin arbiters: one dispatch and one result capture per cycle.
  always_comb begin
    grant_en    = 1'b0;
    grant_idx   = last_grant_q;
    cap_en      = 1'b0;
    cap_idx     = last_cap_q;
    all_idle    = 1'b1;
    gp          = '0;
    cp          = '0;
    cap_counter = '0;
    for (int unsigned off = 1; off <= NUM_CORES; off++) begin
      gp = PTR_W'((32'(last_grant_q) + off) % NUM_CORES);
      cp = PTR_W'((32'(last_cap_q) + off) % NUM_CORES);
      if (!grant_en && busy_q && !abort_w && (remaining_q != '0) &&
          (state_q[gp] == S_IDLE)) begin
        grant_en  = 1'b1;
        grant_idx = gp;
      end
      if (!cap_en && !abort_w && (!res_valid_q || bus.res_ready) &&
          (state_q[cp] == S_REPORT)) begin
        cap_en  = 1'b1;
        cap_idx = cp;
      end
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (state_q[i] != S_IDLE) all_idle = 1'b0;
      if (cap_idx == PTR_W'(i)) cap_counter = bus.wk_counter[64*i +: 64];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) state_q[i] <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE:     if (grant_en && grant_idx == PTR_W'(i)) state_d[i] = S_LOAD;
        S_LOAD:     if (bus.wk_cmd_read[i])  state_d[i] = S_LOAD_REL;
        S_LOAD_REL: if (!bus.wk_cmd_read[i]) state_d[i] = S_GO;
        S_GO:       if (bus.wk_cmd_read[i])  state_d[i] = S_GO_REL;
        S_GO_REL:   if (!bus.wk_cmd_read[i]) state_d[i] = S_RUN;
        S_RUN:      if (bus.wk_done[i])      state_d[i] = S_REPORT;
        S_REPORT:   if (cap_en && cap_idx == PTR_W'(i)) state_d[i] = S_RST;
        S_RST:      if (bus.wk_cmd_read[i])  state_d[i] = S_RST_REL;
        S_RST_REL:  if (!bus.wk_cmd_read[i]) state_d[i] = S_IDLE;
        default:    state_d[i] = S_IDLE;
      endcase
      if (abort_w && (state_q[i] inside {S_LOAD, S_LOAD_REL, S_GO, S_GO_REL, S_RUN, S_REPORT}))
        state_d[i] = S_RST;
    end
  end

  // The command word stays stable through the *_REL phase; only valid drops.
  always_comb begin
    bus.wk_cmd       = '0;
    bus.wk_cmd_valid = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      case (state_q[i])
        S_LOAD:     begin bus.wk_cmd[32*i +: 32] = CMD_READ_REGION; bus.wk_cmd_valid[i] = 1'b1; end
        S_LOAD_REL: bus.wk_cmd[32*i +: 32] = CMD_READ_REGION;
        S_GO:       begin bus.wk_cmd[32*i +: 32] = CMD_START; bus.wk_cmd_valid[i] = 1'b1; end
        S_GO_REL:   bus.wk_cmd[32*i +: 32] = CMD_START;
        S_RST:      begin bus.wk_cmd[32*i +: 32] = CMD_RESTART; bus.wk_cmd_valid[i] = 1'b1; end
        S_RST_REL:  bus.wk_cmd[32*i +: 32] = CMD_RESTART;
        default:    ;
      endcase
    end
  end

  always_comb begin
    busy_d        = busy_q;
    job_done_d    = 1'b0;
    next_region_d = next_region_q;
    remaining_d   = remaining_q;
    res_valid_d   = res_valid_q & ~bus.res_ready;
    if (cap_en) res_valid_d = 1'b1;
    if (abort_w) begin
      remaining_d = '0;
      res_valid_d = 1'b0;
    end
    if (grant_en) begin
      next_region_d = next_region_q + 1'b1;
      remaining_d   = remaining_q - 1'b1;
    end
    if (busy_q && (remaining_q == '0) && all_idle && !res_valid_q) begin
      busy_d     = 1'b0;
      job_done_d = 1'b1;
    end
    // An empty job completes straight from idle without ever raising busy.
    if (!busy_q && bus.start) begin
      if (bus.region_count == '0) begin
        job_done_d = 1'b1;
      end else begin
        busy_d        = 1'b1;
        next_region_d = bus.region_base;
        remaining_d   = bus.region_count;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= 1'b0;
      job_done_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      next_region_q <= '0;
      remaining_q   <= '0;
      res_region_q  <= '0;
      res_counter_q <= '0;
      last_grant_q  <= PTR_W'(NUM_CORES - 1);
      last_cap_q    <= PTR_W'(NUM_CORES - 1);
      for (int unsigned i = 0; i < NUM_CORES; i++) region_q[i] <= '0;
    end else begin
      busy_q        <= busy_d;
      job_done_q    <= job_done_d;
      res_valid_q   <= res_valid_d;
      next_region_q <= next_region_d;
      remaining_q   <= remaining_d;
      if (grant_en) begin
        region_q[grant_idx] <= next_region_q;
        last_grant_q        <= grant_idx;
      end
      if (cap_en) begin
        res_region_q  <= region_q[cap_idx];
        res_counter_q <= cap_counter;
        last_cap_q    <= cap_idx;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.job_done    = job_done_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_region  = res_region_q;
  assign bus.res_counter = res_counter_q;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_wk_region
    assign bus.wk_region[32*g +: 32] = 32'(region_q[g]);
  end

endmodule

// File: tb/tb_des_region_scheduler.sv
// Scoreboard bench for des_region_scheduler with a reactive model of the DES cores.
// Covers the abort path when DES_SCHED_ABORT_EN is defined.
module tb_des_region_scheduler;
  localparam int NC = 4;
  localparam int RW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_region_scheduler_if #(.NUM_CORES(NC), .REGION_W(RW)) wif ();
  des_region_scheduler #(.NUM_CORES(NC), .REGION_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wif.slave)
  );

  int compared = 0, mismatched = 0;
  int done_cnt = 0, loads = 0, restarts = 0;
  logic cmd_seen = 1'b0;
  logic [31:0] exp_q[$];

  function automatic logic [63:0] result_of(input logic [31:0] r);
    return {r ^ 32'hA5A5_A5A5, ~r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Core model: acknowledges each new command, runs 20 cycles after START,
  // then holds done with a counter derived from the region it was loaded with.
  int          run_cnt [NC];
  logic [31:0] seen [NC];
  logic        pv [NC];
  logic [31:0] pc [NC];
  always @(negedge clk) begin
    if (!rst_n) begin
      wif.wk_cmd_read = '0;
      wif.wk_done     = '0;
      wif.wk_counter  = '0;
      for (int i = 0; i < NC; i++) begin
        run_cnt[i] = 0; seen[i] = '0; pv[i] = 1'b0; pc[i] = '0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (wif.wk_cmd_valid[i] && (!pv[i] || wif.wk_cmd[32*i +: 32] != pc[i])) begin
          wif.wk_cmd_read[i] = 1'b1;
          case (wif.wk_cmd[32*i +: 32])
            32'd0: begin seen[i] = wif.wk_region[32*i +: 32]; loads++; end
            32'd1: run_cnt[i] = 20;
            32'd3: begin run_cnt[i] = 0; wif.wk_done[i] = 1'b0; restarts++; end
            default: ;
          endcase
        end else if (!wif.wk_cmd_valid[i]) begin
          wif.wk_cmd_read[i] = 1'b0;
        end
        pv[i] = wif.wk_cmd_valid[i];
        pc[i] = wif.wk_cmd[32*i +: 32];
        if (run_cnt[i] > 0) begin
          run_cnt[i]--;
          if (run_cnt[i] == 0) begin
            wif.wk_done[i] = 1'b1;
            wif.wk_counter[64*i +: 64] = result_of(seen[i]);
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted result.
  logic        hold_v = 1'b0;
  logic [31:0] hold_r, exp_r;
  logic [63:0] hold_c;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (wif.job_done) done_cnt++;
      if (|wif.wk_cmd_valid) cmd_seen = 1'b1;
      if (wif.res_valid && wif.res_ready) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got region %h, required no result", wif.res_region);
        end else begin
          exp_r = exp_q.pop_front();
          check("res_region", 64'(wif.res_region), 64'(exp_r));
          check("res_counter", wif.res_counter, result_of(exp_r));
        end
      end else if (wif.res_valid) begin
        if (hold_v) begin
          check("hold_region", 64'(wif.res_region), 64'(hold_r));
          check("hold_counter", wif.res_counter, hold_c);
        end
        hold_v = 1'b1;
        hold_r = wif.res_region;
        hold_c = wif.res_counter;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic start_job(input logic [31:0] base, input logic [31:0] count, input bit push);
    logic [31:0] r;
    @(posedge clk); #1;
    wif.region_base  = base;
    wif.region_count = count;
    wif.start        = 1'b1;
    if (push) begin
      r = base;
      for (int unsigned k = 0; k < count; k++) begin
        exp_q.push_back(r);
        r = r + 32'd1;
      end
    end
    @(posedge clk); #1;
    wif.start = 1'b0;
  endtask

  task automatic finish_job(input int d0, input string name);
    int t = 0;
    while (done_cnt == d0 && t < 1500) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_cnt == d0) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: job_done not seen in 1500 cycles, required one pulse", name);
    end
    repeat (30) @(posedge clk);
    #1;
    check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_results_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_busy_end"}, 64'(wif.busy), 64'd0);
  endtask

  int d0, l0, r0, t;

  initial begin
    wif.start        = 1'b0;
    wif.region_base  = '0;
    wif.region_count = '0;
    wif.res_ready    = 1'b1;
`ifdef DES_SCHED_ABORT_EN
    wif.abort        = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      64'(wif.busy), 64'd0);
    check("rst_job_done",  64'(wif.job_done), 64'd0);
    check("rst_res_valid", 64'(wif.res_valid), 64'd0);
    check("rst_cmd_valid", 64'(wif.wk_cmd_valid), 64'd0);
    rst_n = 1'b1;

    // Reset asserted while all cores are running.
    start_job(32'h0000_0100, 32'd4, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    check("pre_rst_busy",   64'(wif.busy), 64'd1);
    check("pre_rst_region", 64'(|wif.wk_region), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",      64'(wif.busy), 64'd0);
    check("midrst_job_done",  64'(wif.job_done), 64'd0);
    check("midrst_res_valid", 64'(wif.res_valid), 64'd0);
    check("midrst_cmd_valid", 64'(wif.wk_cmd_valid), 64'd0);
    check("midrst_wk_region", 64'(|wif.wk_region), 64'd0);
    check("midrst_res_region",  64'(wif.res_region), 64'd0);
    check("midrst_res_counter", wif.res_counter, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Six regions over four cores; a start while busy must be ignored.
    d0 = done_cnt;
    start_job(32'h0000_0010, 32'd6, 1'b1);
    repeat (4) @(posedge clk);
    start_job(32'h0000_0999, 32'd2, 1'b0);
    finish_job(d0, "basic");

    // Backpressure: the first result is held for 50 cycles.
    d0 = done_cnt;
    wif.res_ready = 1'b0;
    start_job(32'h0000_0040, 32'd4, 1'b1);
    t = 0;
    while (!wif.res_valid && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_res_valid_seen", 64'(wif.res_valid), 64'd1);
    repeat (50) @(posedge clk);
    #1;
    check("bp_res_valid_held", 64'(wif.res_valid), 64'd1);
    wif.res_ready = 1'b1;
    finish_job(d0, "backpressure");

    // Empty job.
    d0 = done_cnt;
    cmd_seen = 1'b0;
    start_job(32'h0000_0005, 32'd0, 1'b0);
    check("zero_done_pulse", 64'(wif.job_done), 64'd1);
    @(posedge clk); #1;
    check("zero_done_low", 64'(wif.job_done), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("zero_no_cmd",    64'(cmd_seen), 64'd0);
    check("zero_done_once", 64'(done_cnt - d0), 64'd1);
    check("zero_busy",      64'(wif.busy), 64'd0);

    // Region index wraps past all-ones.
    d0 = done_cnt;
    start_job(32'hFFFF_FFFE, 32'd3, 1'b1);
    finish_job(d0, "wrap");

`ifdef DES_SCHED_ABORT_EN
    d0 = done_cnt;
    l0 = loads;
    r0 = restarts;
    start_job(32'h0000_0080, 32'd6, 1'b0);
    t = 0;
    while ((loads - l0) < 2 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_two_loads", 64'((loads - l0) >= 2), 64'd1);
    wif.abort = 1'b1;
    @(posedge clk); #1;
    wif.abort = 1'b0;
    finish_job(d0, "abort");
    check("abort_restarts", 64'(restarts - r0), 64'(loads - l0));
    check("abort_res_valid", 64'(wif.res_valid), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/des_region_scheduler.md
DES_REGION_SCHEDULER -- requirements
Module: des_region_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 4, number of attached DES wrapper cores (2..8).
REQ-002 Parameter REGION_W, default 32, region index width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; launches a job when idle.
REQ-006 region_base  input  REGION_W  first region of the job, sampled on start.
REQ-007 region_count  input  REGION_W  number of regions in the job, sampled on start.
REQ-008 busy  output  1  job in progress.
REQ-009 job_done  output  1  one-cycle pulse when the last result is accepted.
REQ-010 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-011 res_region  output  REGION_W  region index of the presented result.
REQ-012 res_counter  output  64  counter value of the presented result.
REQ-013 wk_cmd  output  32*NUM_CORES  per-core command word; core i uses bits [32i+31:32i].
REQ-014 wk_cmd_valid  output  NUM_CORES  per-core command valid.
REQ-015 wk_region  output  32*NUM_CORES  per-core region operand.
REQ-016 wk_cmd_read  input  NUM_CORES  per-core command-read acknowledge.
REQ-017 wk_done  input  NUM_CORES  per-core done level.
REQ-018 wk_counter  input  64*NUM_CORES  per-core counter result.

Function
REQ-019 Command codes: READ_REGION=0, START=1, RESTART=3.
REQ-020 Per-core FSM states: IDLE, LOAD, LOAD_REL, GO, GO_REL, RUN, REPORT, RST, RST_REL.
REQ-021 Command issue: hold cmd_valid=1 with a stable cmd until cmd_read=1 is seen, then drive cmd_valid=0 in the *_REL state until cmd_read=0 is seen.
REQ-022 Core transitions: IDLE->LOAD on dispatch grant; LOAD->LOAD_REL->GO->GO_REL->RUN; RUN->REPORT when wk_done=1; REPORT->RST on result capture; RST->RST_REL->IDLE.
REQ-023 Dispatch: at most one grant per cycle, round-robin over IDLE cores starting after the last granted core; a grant requires busy=1 and remaining>0.
REQ-024 On grant, the core's region register loads next_region; next_region increments by 1 and remaining decrements by 1 in the same cycle.
REQ-025 next_region wraps modulo 2^REGION_W; no overflow flag.
REQ-026 Result capture: round-robin over cores in REPORT, only when the output slot is empty or is being accepted in the same cycle (res_valid & res_ready); the captured core's counter and region latch into res_counter/res_region.
REQ-027 res_valid rises the cycle after capture and holds, with stable data, until res_ready=1.
REQ-028 start while busy=1 is ignored; start with region_count=0 produces job_done one cycle later and no dispatch.
REQ-029 busy=1 from the cycle after an accepted start until job_done; job_done fires when remaining=0, all cores are IDLE, and no result is pending.
REQ-030 Simultaneous dispatch and capture in one cycle are independent and both occur.

Reset
REQ-031 rst_n=0 immediately forces all cores to IDLE; busy, job_done, res_valid and all wk_cmd_valid go to 0; counters, res_region, res_counter and wk_region clear to 0.
REQ-032 Reset mid-job discards all progress; cores are not sent RESTART.

Configuration
REQ-033 Macro DES_SCHED_ABORT_EN: when defined, add input abort (1 bit); abort=1 while busy sets remaining=0, sends every core in LOAD..REPORT directly to RST, drops any pending result, and pulses job_done after all cores return to IDLE.
REQ-034 When DES_SCHED_ABORT_EN is undefined, there is no abort port and no abort logic.

Verification
REQ-035 Reset: rst_n low mid-RUN -> all outputs 0 in the same cycle, all cores IDLE.
REQ-036 start, base=0x10, count=6, 4 cores, res_ready=1, each core's done after 20 cycles -> regions 0x10..0x15 reported once each, job_done exactly once.
REQ-037 Backpressure: hold res_ready=0 for 50 cycles -> res_valid held, data stable, other cores wait in REPORT, no result lost.
REQ-038 count=0 -> job_done one cycle after start, no wk_cmd_valid asserted.
REQ-039 base=0xFFFFFFFE, count=3 -> regions 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 dispatched.
REQ-040 With DES_SCHED_ABORT_EN: abort after 2 dispatches -> all cores receive RESTART (cmd=3), job_done pulses once, no further res_valid.
